// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter.
//   - ALU opcode encodings (OP_ADD .. OP_ROR); every other code is invalid
//   - bit positions inside the 5-bit response flag vector
//   - FSM state encoding used by alu_arbiter
package alu_arbiter_pkg;

    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_ADD_CARRY = 4'd2;
    localparam logic [3:0] OP_SUB       = 4'd3;
    localparam logic [3:0] OP_INC       = 4'd4;
    localparam logic [3:0] OP_DEC       = 4'd5;
    localparam logic [3:0] OP_AND       = 4'd6;
    localparam logic [3:0] OP_NOT       = 4'd7;
    localparam logic [3:0] OP_ROL       = 4'd8;
    localparam logic [3:0] OP_ROR       = 4'd9;

    // flags = {invalid_op, parity, zero, borrow, c_out}
    localparam int FLAG_C_OUT   = 0;
    localparam int FLAG_BORROW  = 1;
    localparam int FLAG_ZERO    = 2;
    localparam int FLAG_PARITY  = 3;
    localparam int FLAG_INVALID = 4;
    localparam int FLAG_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU datapath.
// Ports:
//   opcode  in  4      operation select (see alu_arbiter_pkg)
//   a, b    in  B_W    operands
//   c_in    in  1      carry-in (used by ADD_CARRY only)
//   y       out B_W    result (0 for invalid opcodes)
//   flags   out 5      {invalid_op, parity, zero, borrow, c_out}
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int B_W = 8
) (
    input  logic [3:0]        opcode,
    input  logic [B_W-1:0]    a,
    input  logic [B_W-1:0]    b,
    input  logic              c_in,
    output logic [B_W-1:0]    y,
    output logic [FLAG_W-1:0] flags
);

    // One extra bit holds carry-out for sums and the borrow for differences.
    logic [B_W:0]   ext;
    logic [B_W-1:0] res;
    logic           carry;
    logic           borrow;
    logic           invalid;

    always_comb begin
        ext     = '0;
        res     = '0;
        carry   = 1'b0;
        borrow  = 1'b0;
        invalid = 1'b0;
        case (opcode)
            OP_ADD: begin
                ext   = {1'b0, a} + {1'b0, b};
                res   = ext[B_W-1:0];
                carry = ext[B_W];
            end
            OP_ADD_CARRY: begin
                ext   = {1'b0, a} + {1'b0, b} + {{B_W{1'b0}}, c_in};
                res   = ext[B_W-1:0];
                carry = ext[B_W];
            end
            OP_INC: begin
                ext   = {1'b0, a} + {{B_W{1'b0}}, 1'b1};
                res   = ext[B_W-1:0];
                carry = ext[B_W];
            end
            OP_SUB: begin
                ext    = {1'b0, a} - {1'b0, b};
                res    = ext[B_W-1:0];
                borrow = ext[B_W];
            end
            OP_DEC: begin
                ext    = {1'b0, a} - {{B_W{1'b0}}, 1'b1};
                res    = ext[B_W-1:0];
                borrow = ext[B_W];
            end
            OP_AND:  res = a & b;
            OP_NOT:  res = ~a;
            OP_ROL:  res = {a[B_W-2:0], a[B_W-1]};
            OP_ROR:  res = {a[0], a[B_W-1:1]};
            default: invalid = 1'b1;
        endcase
    end

    // res stays 0 for invalid opcodes, which yields zero = 1 and parity = 0.
    always_comb begin
        y                   = res;
        flags               = '0;
        flags[FLAG_C_OUT]   = carry;
        flags[FLAG_BORROW]  = borrow;
        flags[FLAG_ZERO]    = ~|res;
        flags[FLAG_PARITY]  = ^res;
        flags[FLAG_INVALID] = invalid;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU, one operation in flight.
// IDLE grants one port (round-robin on contention), EXEC registers the ALU
// result, RESP presents it until the consumer accepts.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake per port
//   reqN_opcode/_a/_b/_c_in       operation and operands per port
//   rsp_valid / rsp_ready         response handshake
//   rsp_id, rsp_y, rsp_flags      owner, result, {invalid,parity,zero,borrow,c_out}
//   invalid_cnt                   saturating count of invalid opcodes executed
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int B_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_opcode,
    input  logic [B_W-1:0]    req0_a,
    input  logic [B_W-1:0]    req0_b,
    input  logic              req0_c_in,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_opcode,
    input  logic [B_W-1:0]    req1_a,
    input  logic [B_W-1:0]    req1_b,
    input  logic              req1_c_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [B_W-1:0]    rsp_y,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic [7:0]        invalid_cnt
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t state, state_nxt;

    logic last_grant;
    logic grant_vld;
    logic grant_id;
    logic accept;

    logic [3:0]        op_p0;
    logic [B_W-1:0]    a_p0;
    logic [B_W-1:0]    b_p0;
    logic              cin_p0;
    logic              id_p0;

    logic [B_W-1:0]    alu_y_p1;
    logic [FLAG_W-1:0] alu_flags_p1;

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = grant_vld & ~grant_id;
                req1_ready = grant_vld &  grant_id;
                if (grant_vld) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_valid && rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Ready is derived from valid, so in IDLE a valid port is accepted.
    assign accept = (state == ST_IDLE) & grant_vld;

    // ---- stage p0: operand capture at handshake ----
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0  <= grant_id ? req1_opcode : req0_opcode;
            a_p0   <= grant_id ? req1_a      : req0_a;
            b_p0   <= grant_id ? req1_b      : req0_b;
            cin_p0 <= grant_id ? req1_c_in   : req0_c_in;
            id_p0  <= grant_id;
        end
    end

    // ---- stage p1: ALU evaluation of captured operands ----
    alu #(.B_W(B_W)) u_alu (
        .opcode (op_p0),
        .a      (a_p0),
        .b      (b_p0),
        .c_in   (cin_p0),
        .y      (alu_y_p1),
        .flags  (alu_flags_p1)
    );

    // ---- response registers: loaded in EXEC, valid raised one cycle later ----
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_y       <= '0;
            rsp_flags   <= '0;
            invalid_cnt <= '0;
        end else begin
            if (accept) last_grant <= grant_id;
            if (state == ST_EXEC) begin
                rsp_id    <= id_p0;
                rsp_y     <= alu_y_p1;
                rsp_flags <= alu_flags_p1;
                if (alu_flags_p1[FLAG_INVALID]) invalid_cnt <= sat_inc(invalid_cnt);
            end
            if (state == ST_RESP) begin
                if (!rsp_valid)     rsp_valid <= 1'b1;
                else if (rsp_ready) rsp_valid <= 1'b0;
            end
        end
    end

endmodule
